// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the multicycle sequencer and the datapath muxes.
package cpu_ctrl_pkg;

  typedef logic [5:0] opcode_t;
  typedef logic [5:0] funct_t;
  typedef logic [1:0] sel_t;
  typedef logic [2:0] alu_op_t;

  // PC value loaded by the datapath when pc_src selects the jump/reset path on a trap
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecR,
    StExecI,
    StAddr,
    StMemRd,
    StMemWr,
    StWbR,
    StWbI,
    StWbMem,
    StBranch,
    StJump,
    StTrap
  } state_e;

  typedef enum logic [2:0] {
    ClsRtype,
    ClsAddi,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJump,
    ClsIllegal
  } iclass_e;

  localparam opcode_t OpRtype = 6'h00;
  localparam opcode_t OpAddi  = 6'h08;
  localparam opcode_t OpLw    = 6'h23;
  localparam opcode_t OpSw    = 6'h2B;
  localparam opcode_t OpBeq   = 6'h04;
  localparam opcode_t OpJ     = 6'h02;

  localparam funct_t FnAdd = 6'h20;
  localparam funct_t FnSub = 6'h22;
  localparam funct_t FnAnd = 6'h24;
  localparam funct_t FnNot = 6'h27;
  localparam funct_t FnSlt = 6'h2A;

  localparam sel_t ASelPc   = 2'd0;
  localparam sel_t ASelRegA = 2'd1;
  localparam sel_t ASelNotA = 2'd2;
  localparam sel_t ASelMdr  = 2'd3;

  localparam sel_t BSelRegB   = 2'd0;
  localparam sel_t BSelFour   = 2'd1;
  localparam sel_t BSelImm    = 2'd2;
  localparam sel_t BSelImmSh2 = 2'd3;

  localparam alu_op_t AluPassA = 3'd0;
  localparam alu_op_t AluAdd   = 3'd1;
  localparam alu_op_t AluSub   = 3'd2;
  localparam alu_op_t AluAnd   = 3'd3;
  localparam alu_op_t AluSlt   = 3'd7;

  localparam sel_t PcSrcAlu    = 2'd0;
  localparam sel_t PcSrcAluOut = 2'd1;
  localparam sel_t PcSrcJump   = 2'd2;

endpackage

// File: rtl/alu_operand_seq_if.sv
// Control bus between the sequencer (master) and the datapath/IR/memory side (slave).
interface alu_operand_seq_if;
  import cpu_ctrl_pkg::*;

  opcode_t opcode;
  funct_t  funct;
  logic    zero;
  logic    mem_ready;

  sel_t    alu_a_sel;
  sel_t    alu_b_sel;
  alu_op_t alu_op;
  logic    mem_read;
  logic    mem_write;
  logic    ir_write;
  logic    pc_write;
  logic    reg_write;
  logic    aluout_write;
  sel_t    pc_src;
  logic    reg_dst;
  logic    mem_to_reg;
  logic    trap;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output alu_a_sel, alu_b_sel, alu_op, mem_read, mem_write, ir_write, pc_write,
           reg_write, aluout_write, pc_src, reg_dst, mem_to_reg, trap
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  alu_a_sel, alu_b_sel, alu_op, mem_read, mem_write, ir_write, pc_write,
           reg_write, aluout_write, pc_src, reg_dst, mem_to_reg, trap
  );
endinterface

// File: rtl/instr_class_decode.sv
// Combinational opcode/funct classifier: instruction class plus R-type legality and ALU op.
module instr_class_decode
  import cpu_ctrl_pkg::*;
(
  input  opcode_t opcode,
  input  funct_t  funct,
  output iclass_e iclass,
  output logic    funct_legal,
  output logic    funct_is_not,
  output alu_op_t funct_op
);

  // Opcode to instruction class; anything unlisted is illegal
  always_comb begin
    iclass = ClsIllegal;
    unique case (opcode)
      OpRtype: iclass = ClsRtype;
      OpAddi:  iclass = ClsAddi;
      OpLw:    iclass = ClsLoad;
      OpSw:    iclass = ClsStore;
      OpBeq:   iclass = ClsBranch;
      OpJ:     iclass = ClsJump;
      default: iclass = ClsIllegal;
    endcase
  end

  // R-type funct to ALU op; 'not' passes the inverted A operand straight through
  always_comb begin
    funct_legal  = 1'b1;
    funct_is_not = 1'b0;
    funct_op     = AluPassA;
    unique case (funct)
      FnAdd:   funct_op = AluAdd;
      FnSub:   funct_op = AluSub;
      FnAnd:   funct_op = AluAnd;
      FnSlt:   funct_op = AluSlt;
      FnNot:   funct_is_not = 1'b1;
      default: funct_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_operand_seq.sv
// Multicycle control sequencer: drives ALU operand selects, ALU op and datapath strobes.
module alu_operand_seq
  import cpu_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  alu_operand_seq_if.master  bus
);

  state_e  state_q, state_d;
  iclass_e iclass;
  logic    funct_legal;
  logic    funct_is_not;
  alu_op_t funct_op;

  instr_class_decode u_decode (
    .opcode       (bus.opcode),
    .funct        (bus.funct),
    .iclass       (iclass),
    .funct_legal  (funct_legal),
    .funct_is_not (funct_is_not),
    .funct_op     (funct_op)
  );

  // State register; reset forces IDLE so every output drops immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and outputs; only FETCH and BRANCH strobes look at inputs
  always_comb begin
    state_d          = state_q;
    bus.alu_a_sel    = ASelPc;
    bus.alu_b_sel    = BSelRegB;
    bus.alu_op       = AluPassA;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.ir_write     = 1'b0;
    bus.pc_write     = 1'b0;
    bus.reg_write    = 1'b0;
    bus.aluout_write = 1'b0;
    bus.pc_src       = PcSrcAlu;
    bus.reg_dst      = 1'b0;
    bus.mem_to_reg   = 1'b0;
    bus.trap         = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        bus.mem_read  = 1'b1;
        bus.alu_a_sel = ASelPc;
        bus.alu_b_sel = BSelFour;
        bus.alu_op    = AluAdd;
        bus.pc_src    = PcSrcAlu;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Speculatively compute the branch target into ALUOut
        bus.alu_a_sel    = ASelPc;
        bus.alu_b_sel    = BSelImmSh2;
        bus.alu_op       = AluAdd;
        bus.aluout_write = 1'b1;
        unique case (iclass)
          ClsRtype:            state_d = StExecR;
          ClsAddi:             state_d = StExecI;
          ClsLoad, ClsStore:   state_d = StAddr;
          ClsBranch:           state_d = StBranch;
          ClsJump:             state_d = StJump;
          default:             state_d = StTrap;
        endcase
      end
      StExecR: begin
        if (funct_legal) begin
          bus.alu_a_sel    = funct_is_not ? ASelNotA : ASelRegA;
          bus.alu_b_sel    = BSelRegB;
          bus.alu_op       = funct_op;
          bus.aluout_write = 1'b1;
          state_d          = StWbR;
        end else begin
          state_d = StTrap;
        end
      end
      StExecI, StAddr: begin
        bus.alu_a_sel    = ASelRegA;
        bus.alu_b_sel    = BSelImm;
        bus.alu_op       = AluAdd;
        bus.aluout_write = 1'b1;
        if (state_q == StExecI)       state_d = StWbI;
        else if (iclass == ClsStore)  state_d = StMemWr;
        else                          state_d = StMemRd;
      end
      StMemRd: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ready) state_d = StWbMem;
      end
      StMemWr: begin
        bus.mem_write = 1'b1;
        if (bus.mem_ready) state_d = StFetch;
      end
      StWbR: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        state_d       = StFetch;
      end
      StWbI: begin
        bus.reg_write = 1'b1;
        state_d       = StFetch;
      end
      StWbMem: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d        = StFetch;
      end
      StBranch: begin
        bus.alu_a_sel = ASelRegA;
        bus.alu_b_sel = BSelRegB;
        bus.alu_op    = AluSub;
        bus.pc_src    = PcSrcAluOut;
        bus.pc_write  = bus.zero;
        state_d       = StFetch;
      end
      StJump: begin
        bus.pc_src   = PcSrcJump;
        bus.pc_write = 1'b1;
        state_d      = StFetch;
      end
      StTrap: begin
        bus.trap     = 1'b1;
        bus.pc_src   = PcSrcJump;
        bus.pc_write = 1'b1;
        state_d      = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
